// File: rtl/piso_shift_transmitter.sv
// rtl/piso_shift_transmitter.sv - parallel-in serial-out word transmitter, MSB index first
// Optional even-parity trailer cycle enabled by defining PISO_PARITY_EN.
module piso_shift_transmitter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] par_in,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
`ifdef PISO_PARITY_EN
    output logic             parity_valid,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [0:WIDTH-1] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = par_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^par_in;
`endif
                end
            end
            SHIFT: begin
                // Shift toward the high index so ser_out always taps index WIDTH-1.
                if (en) begin
                    shreg_d = {1'b0, shreg_q[0:WIDTH-2]};
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ready is masked by rst directly so it drops without waiting for a clock.
    assign ready    = !rst && (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign shift_en = (state_q == SHIFT) && en;
    assign done     = done_q;
`ifdef PISO_PARITY_EN
    assign parity_valid = (state_q == PARITY);
    assign ser_out      = ((state_q == SHIFT) && shreg_q[WIDTH-1]) ||
                          ((state_q == PARITY) && par_q);
`else
    assign ser_out      = (state_q == SHIFT) && shreg_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// tb/tb_piso_shift_transmitter.sv - directed bench for piso_shift_transmitter with a receiver model
module tb_piso_shift_transmitter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [0:W-1] par_in = '0;
    logic         load = 1'b0;
    logic         en = 1'b0;
    logic         ready, ser_out, shift_en, busy, done;
`ifdef PISO_PARITY_EN
    logic         parity_valid;
`endif
    logic [0:W-1] rq = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_shift_transmitter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .par_in   (par_in),
        .load     (load),
        .ready    (ready),
        .en       (en),
        .ser_out  (ser_out),
        .shift_en (shift_en),
        .busy     (busy),
`ifdef PISO_PARITY_EN
        .parity_valid (parity_valid),
`endif
        .done     (done)
    );

    // Six-bit serial-in receiver: serIn enters Q[0] and moves toward Q[W-1].
    always @(posedge clk)
        if (shift_en) rq <= {ser_out, rq[0:W-2]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT ready; returns at a negedge.
    task automatic xfer(input logic [0:W-1] w, input int stall_at, input int stall_n,
                        input bit chain, input logic [0:W-1] nxt);
        par_in = w;
        load   = 1'b1;
        en     = 1'b1;
        @(negedge clk);
        if (chain) par_in = nxt;
        else begin
            load   = 1'b0;
            par_in = ~w;
        end
        for (int k = 0; k < W; k++) begin
            chk($sformatf("bit%0d", k), ser_out, w[W-1-k]);
            chk($sformatf("shift_en%0d", k), shift_en, 1'b1);
            chk($sformatf("busy%0d", k), busy, 1'b1);
            chk($sformatf("ready%0d", k), ready, 1'b0);
            if (k == stall_at) begin
                en = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_hold", ser_out, w[W-1-k]);
                    chk("stall_shift_en", shift_en, 1'b0);
                    chk("stall_busy", busy, 1'b1);
                end
                en = 1'b1;
            end
            @(negedge clk);
        end
`ifdef PISO_PARITY_EN
        chk("parity_bit", ser_out, ^w);
        chk("parity_valid", parity_valid, 1'b1);
        chk("parity_shift_en", shift_en, 1'b0);
        chk("parity_busy", busy, 1'b1);
        chk("parity_no_done", done, 1'b0);
        @(negedge clk);
        chk("parity_valid_off", parity_valid, 1'b0);
`endif
        chk("done", done, 1'b1);
        chk("done_ready", ready, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("gap_shift_en", shift_en, 1'b0);
        chk("receiver_q", rq, w);
        if (!chain) begin
            @(negedge clk);
            chk("done_pulse_end", done, 1'b0);
            chk("idle_ready", ready, 1'b1);
            chk("idle_ser_out", ser_out, 1'b0);
        end
    endtask

    initial begin
        #3;
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_shift_en", shift_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ready, 1'b1);

        xfer(6'b101100, -1, 0, 1'b0, '0);
        xfer(6'b101100, 1, 3, 1'b0, '0);
        xfer(6'b111000, -1, 0, 1'b1, 6'b010101);
        xfer(6'b010101, -1, 0, 1'b0, '0);

        // Abort after three bits of 110011 with an asynchronous reset pulse.
        par_in = 6'b110011;
        load   = 1'b1;
        en     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("abort_bit0", ser_out, 1'b1);
        @(negedge clk);
        chk("abort_bit1", ser_out, 1'b1);
        @(negedge clk);
        chk("abort_bit2", ser_out, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b0);
        chk("abort_ser_out", ser_out, 1'b0);
        chk("abort_shift_en", shift_en, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_release_ready", ready, 1'b1);
        chk("abort_release_done", done, 1'b0);
        xfer(6'b000111, -1, 0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
